// File: rtl/fifo_pkg.sv
// Shared definitions for the step-driven FIFO: the mode encodings and a decode helper.
// Latency: not applicable (constants and a pure function only).
// Backpressure: not applicable.
package fifo_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD      = 2'b00;
  localparam mode_t MODE_SHIFT_IN  = 2'b01;
  localparam mode_t MODE_SHIFT_OUT = 2'b10;
  localparam mode_t MODE_CLEAR     = 2'b11;

  // True when the mode changes FIFO state if it fires (everything but HOLD).
  function automatic logic modeIsActive(input mode_t m);
    return m != MODE_HOLD;
  endfunction

endpackage

// File: rtl/fifo_step_pipe_step_edge.sv
// Rising-edge detector: pulse is high for the cycle where in==1 and last cycle's in==0.
// Latency: pulse is combinational from in against the one-cycle-old registered copy.
// Backpressure: none; a level held high yields a single pulse. The history register
// resets to 1 so a level already high when reset releases is not seen as an edge.
module step_edge (
  input  logic gclk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic stepQ;

  // Remember last cycle's strobe level; reset high to suppress a spurious edge.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) stepQ <= 1'b1;
    else        stepQ <= in;
  end

  assign pulse = in & ~stepQ;

endmodule

// File: rtl/fifo_step_pipe.sv
// Step-strobed FIFO: one operation (hold/push/pop/clear) per rising edge of step.
// Latency: the operation lands on the clock edge that sees the step rise; outputs show it after that edge.
// Backpressure: none; push when full and pop when empty are dropped and flagged via sticky ovf/unf.
module fifo_step_pipe
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     gclk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     step,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             fire;
  logic             pushOk;
  logic             popOk;

  step_edge uStepEdge (
    .gclk  (gclk),
    .rst_n (rst_n),
    .in    (step),
    .pulse (fire)
  );

  // Mode is only looked at when an operation fires; mode changes alone do nothing.
  assign pushOk = fire && (mode == MODE_SHIFT_IN)  && !full;
  assign popOk  = fire && (mode == MODE_SHIFT_OUT) && !empty;

  // Data array carries no reset; stale words are hidden by count/empty.
  always_ff @(posedge gclk) begin
    if (pushOk) mem[wrPtr] <= din;
  end

  // Pointers, occupancy and sticky error flags advance only on a fired operation.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (fire && modeIsActive(mode)) begin
      case (mode)
        MODE_SHIFT_IN: begin
          if (pushOk) begin
            wrPtr <= wrPtr + AW'(1);
            count <= count + CW'(1);
          end else begin
            ovf <= 1'b1;
          end
        end
        MODE_SHIFT_OUT: begin
          if (popOk) begin
            rdPtr <= rdPtr + AW'(1);
            count <= count - CW'(1);
          end else begin
            unf <= 1'b1;
          end
        end
        default: begin
          wrPtr <= '0;
          rdPtr <= '0;
          count <= '0;
          ovf   <= 1'b0;
          unf   <= 1'b0;
        end
      endcase
    end
  end

  // Status and head word come from registered state only.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rdPtr];

endmodule

// File: doc/fifo_step_pipe.md
FIFO_STEP_PIPE -- requirements
Module: fifo_step_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning entry count; it SHALL be a power of two, 2..256.
REQ-003 The block SHALL have `gclk` input 1: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have `rst_n` input 1: asynchronous, active-low reset.
REQ-005 The block SHALL have `mode` input 2: operation select, encoded 00 HOLD, 01 SHIFT_IN, 10 SHIFT_OUT, 11 CLEAR.
REQ-006 The block SHALL have `step` input 1: operation strobe; only its rising edge is acted on (level-held step = one operation).
REQ-007 The block SHALL have `din` input WIDTH: word to push on SHIFT_IN.
REQ-008 The block SHALL have `dout` output WIDTH: oldest stored word (head); all-zero when empty.
REQ-009 The block SHALL have `count` output $clog2(DEPTH)+1: number of stored words.
REQ-010 The block SHALL have `full` output 1, high when count==DEPTH, and `empty` output 1, high when count==0.
REQ-011 The block SHALL have `ovf` output 1, a sticky flag for a push attempted while full.
REQ-012 The block SHALL have `unf` output 1, a sticky flag for a pop attempted while empty.

Function
REQ-013 The block SHALL register `step` each cycle into step_q; an operation fires on the edge where step==1 and step_q==0.
REQ-014 A fired operation SHALL take effect at that same rising edge, with outputs showing the new state after that edge (latency 1 clock from step rising).
REQ-015 HOLD, or no fired operation, SHALL leave storage, pointers, count and flags unchanged.
REQ-016 SHIFT_IN not full SHALL write din at wr_ptr, increment wr_ptr modulo DEPTH, and increment count.
REQ-017 SHIFT_IN while full SHALL leave storage/count unchanged and set ovf.
REQ-018 SHIFT_OUT not empty SHALL increment rd_ptr modulo DEPTH and decrement count; the popped word is the dout value before the edge.
REQ-019 SHIFT_OUT while empty SHALL leave state unchanged and set unf.
REQ-020 CLEAR SHALL synchronously zero pointers and count and clear ovf/unf; storage contents need not be cleared.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering across wrap.
REQ-022 dout, full and empty SHALL be derived from registered state only, with no combinational path from din, mode or step.
REQ-023 A mode change without a step rising edge SHALL have no effect, and mode SHALL be sampled only on the firing edge.

Reset
REQ-024 rst_n low SHALL immediately force pointers=0, count=0, step_q=1, ovf=0 and unf=0; hence dout=0, empty=1 and full=0.
REQ-025 Because step_q resets to 1, a step held high through reset release SHALL NOT fire an operation.
REQ-026 Reset asserted mid-operation SHALL override any firing edge, and the FIFO SHALL come up empty.

Structure
REQ-027 Mode encodings (MODE_HOLD, MODE_SHIFT_IN, MODE_SHIFT_OUT, MODE_CLEAR) SHALL reside in shared package fifo_pkg.
REQ-028 Rising-edge detection SHALL be a sub-module `step_edge` with ports gclk, rst_n, in and pulse.
REQ-029 Storage SHALL be a DEPTH x WIDTH register array with no reset on data bits.

Verification
REQ-030 Reset, then 3 SHIFT_IN pulses with din=8'hA1,8'hB2,8'hC3 -> count=3, dout=8'hA1, empty=0.
REQ-031 Continuing from REQ-030: 2 SHIFT_OUT pulses -> dout=8'hC3, count=1; a further pop gives empty=1 and dout=0.
REQ-032 DEPTH=8: 8 pushes of 1..8, then a 9th push of 8'hFF -> full=1, ovf=1, count=8; then 8 pops return 1..8 in order.
REQ-033 Wrap: push 6, pop 6, push 5 (8'h10..8'h14) -> pops return 8'h10..8'h14 in order across wrap.
REQ-034 step held high for 20 cycles in SHIFT_IN -> exactly one push (count +1); pop while empty -> unf=1; CLEAR -> count=0, ovf=unf=0.
REQ-035 rst_n pulsed low mid-sequence with count=4 and step high -> count=0, empty=1 immediately; no push on reset release.
